morse_key_sequencer: RTL
========================

# morse_key_sequencer

Front end of the Morse datapath: turns a raw, already-synchronized key level into timed symbols for the letter decoder. It measures key-down (mark) and key-up (space) durations in divided-clock ticks, classifies each mark as dot or dash, and inserts end-of-letter markers on a letter gap, a `send` press, or a full 5-symbol letter. Symbols go to the decoder over a valid/ready handshake using the 2-bit symbol code the decoder already consumes.

## Interface
- `DOT_MIN`, 1: minimum mark length in ticks; shorter marks are glitches and are discarded.
- `DASH_TICKS`, 3: mark length in ticks at or above which the mark is a dash.
- `LETTER_GAP`, 3: space length in ticks that closes a letter.
- `CNT_W`, 8: width of the mark and space counters.
- `clk  in  1`: system clock, 100 MHz.
- `reset  in  1`: synchronous, active-low reset.
- `tick  in  1`: one-cycle timing enable from the clock divider. All duration counting advances only on `tick`.
- `key  in  1`: key level, 1 = pressed, already synchronized and debounced.
- `send  in  1`: level input; a rising edge forces end-of-letter.
- `sym_ready  in  1`: decoder accepts a symbol.
- `sym_valid  out  1`: symbol available.
- `sym_code  out  2`: 01 = dot, 10 = dash, 11 = end-of-letter, 00 = none. Reads 00 whenever `sym_valid` = 0.
- `sym_cnt  out  3`: symbols emitted in the current letter, 0–5.
- `busy  out  1`: high in MARK or SPACE, or while any symbol or end-of-letter is pending.
- `overrun  out  1`: sticky; set when a dot or dash is dropped. Cleared only by reset.

## Operation
- States and transitions:
  - IDLE → MARK on a `key` rising edge.
  - MARK → SPACE on a `key` falling edge.
  - SPACE → MARK on a `key` rising edge.
  - SPACE → IDLE when the letter gap is reached or end-of-letter is queued.
- Edge detection uses `key_q` and `send_q` registers, both reset to 0.
- Mark counter:
  - Cleared on entry to MARK.
  - Increments on `tick` while in MARK.
  - Saturates at 2^CNT_W−1, with no wrap.
- Classification at the `key` falling edge:
  - count < `DOT_MIN`: discard the mark. `sym_cnt` is unchanged.
  - count < `DASH_TICKS`: dot.
  - otherwise: dash.
- Space counter:
  - Cleared on entry to SPACE.
  - Increments on `tick` and saturates like the mark counter.
  - When it reaches `LETTER_GAP` with `sym_cnt` > 0, queue end-of-letter and go to IDLE.
  - If `sym_cnt` = 0 when the gap is reached (every mark was a glitch), return to IDLE without queuing end-of-letter.
- A `send` rising edge with `sym_cnt` > 0 queues end-of-letter. With `sym_cnt` = 0 it does nothing.
- When the 5th dot or dash is emitted, end-of-letter is queued automatically.
- End-of-letter queuing is idempotent: the `pend_eol` flag absorbs repeated triggers.
- Output register:
  - Holds one symbol. `sym_code` is stable while `sym_valid` and not `sym_ready`.
  - A transfer happens when `sym_valid` and `sym_ready` are both high.
  - A dot or dash classified while the register is occupied and not transferring is dropped and sets `overrun`. It does not increment `sym_cnt`.
  - End-of-letter is never dropped. `pend_eol` holds it until the register is free.
- `sym_cnt`:
  - Increments when a dot or dash is loaded into the output register.
  - Returns to 0 when end-of-letter is loaded.
- Simultaneous events:
  - Release and `send` in the same cycle: the dot or dash is loaded first, end-of-letter follows on the next free slot.
  - A key press while end-of-letter is pending: enter MARK normally. The new mark belongs to the next letter.
- Reset mid-operation: all state is discarded at the next `clk` edge. No partial symbol is emitted.

## Timing
- Reset values:
  - State = IDLE.
  - `sym_valid`, `sym_code`, `sym_cnt`, `busy`, `overrun` = 0.
  - Both counters, `key_q`, `send_q`, `pend_eol` = 0.
- Symbol latency:
  - Dot or dash: `sym_valid` rises 1 `clk` after the cycle in which `key` = 0 is sampled with `key_q` = 1.
  - End-of-letter from a gap: `sym_valid` rises 1 `clk` after the tick on which the space count reaches `LETTER_GAP`.
- Back-to-back symbols: with `sym_ready` held high, the output register can accept a new symbol every cycle.
- Handshake: `sym_valid` drops the cycle after a transfer unless a queued end-of-letter is loaded in that same edge.

## Structure
- Shared package holds:
  - the symbol code constants (`SYM_NONE`, `SYM_DOT`, `SYM_DASH`, `SYM_EOL`), which are also used by the decoder;
  - the state enum;
  - the max-symbols-per-letter constant, 5.
- One natural sub-module, `tick_counter`: a saturating counter with clear and enable, instanced for both mark and space.

## Test plan
- Dot: with `tick` every cycle, hold `key` for 2 ticks and release; after 3 more ticks → dot, then end-of-letter. `sym_cnt` reads 1, then 0.
- Glitch: hold `key` for 0 ticks (1 cycle between ticks) → no symbol. `sym_cnt` stays 0 and nothing is emitted after the gap.
- Five symbols: 5 dashes of 4 ticks each with 1-tick spaces → 10,10,10,10,10 then 11 immediately after the 5th symbol. No `overrun`.
- Backpressure: hold `sym_ready` = 0 and enter dot, dot → first dot held stable, second dot dropped, `overrun` = 1. After `sym_ready` = 1, end-of-letter still appears.
- Release and `send` in the same cycle → 01 then 11 on consecutive transfers.
- Reset: drive `reset` = 0 in the middle of a mark → next cycle all outputs are 0 and state is IDLE. Releasing the key afterwards produces no symbol.

Source files
------------

// File: rtl/morse_key_sequencer_pkg.sv
// Shared definitions for the Morse datapath: symbol codes consumed by the letter
// decoder, the key-sequencer state encoding and the per-letter symbol limit.
package morse_key_sequencer_pkg;

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_EOL  = 2'b11;

  localparam int unsigned MAX_SYMS = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

endpackage

// File: rtl/morse_key_sequencer_tick_counter.sv
// Saturating duration counter: synchronous clear has priority over the tick
// enable, and the count sticks at all-ones instead of wrapping.
module tick_counter
  import morse_key_sequencer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/morse_key_sequencer.sv
// Key front end: times marks and spaces in divided-clock ticks, classifies marks
// as dot/dash and frames letters with end-of-letter symbols on a one-deep output.
module morse_key_sequencer
  import morse_key_sequencer_pkg::*;
#(
  parameter int DOT_MIN    = 1,
  parameter int DASH_TICKS = 3,
  parameter int LETTER_GAP = 3,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key,
  input  logic       send,
  input  logic       sym_ready,
  output logic       sym_valid,
  output logic [1:0] sym_code,
  output logic [2:0] sym_cnt,
  output logic       busy,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] DOT_MIN_C  = CNT_W'(DOT_MIN);
  localparam logic [CNT_W-1:0] DASH_C     = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] GAP_M1_C   = CNT_W'(LETTER_GAP - 1);
  localparam logic [2:0]       LAST_SYM_C = 3'(MAX_SYMS - 1);

  state_t           state, state_nxt;
  logic             key_q, send_q;
  logic             pend_eol;
  logic [CNT_W-1:0] mark_cnt, space_cnt;

  logic key_rise, key_fall, send_rise;
  logic in_mark, in_space;
  logic classify, gap_hit, slot_free;
  logic sym_load, sym_drop, letter_open, eol_trig, eol_load;
  logic [1:0] cls_code;

  assign key_rise  = key & ~key_q;
  assign key_fall  = ~key & key_q;
  assign send_rise = send & ~send_q;
  assign in_mark   = (state == ST_MARK);
  assign in_space  = (state == ST_SPACE);

  tick_counter #(.CNT_W(CNT_W)) u_mark_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (key_rise & ~in_mark),
    .en    (tick & in_mark),
    .count (mark_cnt)
  );

  tick_counter #(.CNT_W(CNT_W)) u_space_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (in_mark & key_fall),
    .en    (tick & in_space),
    .count (space_cnt)
  );

  // The gap fires on the tick that would bring the space count up to LETTER_GAP,
  // so the end-of-letter lands in the output register on that same edge.
  assign classify  = in_mark & key_fall & (mark_cnt >= DOT_MIN_C);
  assign cls_code  = (mark_cnt >= DASH_C) ? SYM_DASH : SYM_DOT;
  assign gap_hit   = in_space & tick & (space_cnt >= GAP_M1_C);
  assign slot_free = ~sym_valid | sym_ready;

  // A pending end-of-letter closes the previous letter, so it owns the free slot
  // ahead of a freshly classified mark; that mark is then dropped.
  assign sym_load    = classify & slot_free & ~pend_eol;
  assign sym_drop    = classify & ~sym_load;
  assign letter_open = (sym_cnt != 3'd0) | sym_load;
  assign eol_trig    = letter_open &
                       (gap_hit | send_rise | (sym_load & (sym_cnt == LAST_SYM_C)));
  assign eol_load    = slot_free & (pend_eol | (eol_trig & ~sym_load));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE) | sym_valid | pend_eol;
    unique case (state)
      ST_IDLE: begin
        if (key_rise) state_nxt = ST_MARK;
      end
      ST_MARK: begin
        if (key_fall) state_nxt = ST_SPACE;
      end
      ST_SPACE: begin
        if (key_rise) begin
          state_nxt = ST_MARK;
        end else if (gap_hit | pend_eol | eol_trig) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_q     <= 1'b0;
      send_q    <= 1'b0;
      pend_eol  <= 1'b0;
      sym_valid <= 1'b0;
      sym_code  <= SYM_NONE;
      sym_cnt   <= 3'd0;
      overrun   <= 1'b0;
    end else begin
      key_q    <= key;
      send_q   <= send;
      pend_eol <= (pend_eol | eol_trig) & ~eol_load;
      if (sym_drop) overrun <= 1'b1;
      if (sym_load) begin
        sym_valid <= 1'b1;
        sym_code  <= cls_code;
        sym_cnt   <= sym_cnt + 3'd1;
      end else if (eol_load) begin
        sym_valid <= 1'b1;
        sym_code  <= SYM_EOL;
        sym_cnt   <= 3'd0;
      end else if (sym_ready) begin
        sym_valid <= 1'b0;
        sym_code  <= SYM_NONE;
      end
    end
  end

endmodule
